// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the MULTU/DIVU sequencer and the decoder.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

    // funct field encodings recognised by the decoder
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Decoder <-> sequencer bus for MULTU/DIVU requests and HI/LO results.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    // start is a one-shot request, taken only when the sequencer is not busy and
    // flush is low; completion is a single-cycle done pulse with hi/lo already valid.
    logic             start;
    logic             op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             flush;
    logic             busy;
    logic             done;
    logic             divzero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srca, srcb, flush,
        input  busy, done, divzero, hi, lo
    );

    modport slave (
        input  start, op, srca, srcb, flush,
        output busy, done, divzero, hi, lo
    );

endinterface

// File: rtl/muldiv_sequencer_step.sv
// One combinational iteration of the shift-add multiplier or restoring divider.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             op,
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] mplr_i,
    input  logic [WIDTH-1:0] operand_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] mplr_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] rem_sub;
    logic           fits;

    always_comb begin
        // acc[W] is always 0 on entry, so adding the full acc equals acc[W-1:0] + mcand
        sum     = acc_i + (mplr_i[0] ? {1'b0, operand_i} : '0);
        rem_sh  = {acc_i[WIDTH-1:0], mplr_i[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, operand_i};
        fits    = (rem_sh >= {1'b0, operand_i});

        if (op == OP_MULTU) begin
            acc_o  = {1'b0, sum[WIDTH:1]};
            mplr_o = {sum[0], mplr_i[WIDTH-1:1]};
        end else begin
            acc_o  = fits ? rem_sub : rem_sh;
            mplr_o = {mplr_i[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU controller: FSM, iteration counter and the HI/LO registers.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    muldiv_sequencer_if.slave   bus,
    output state_t              state_dbg
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             divzero_q, divzero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             step_op;
    logic [WIDTH:0]   step_acc;
    logic [WIDTH-1:0] step_mplr;
    logic             accept;

    assign step_op = (state_q == DIV) ? OP_DIVU : OP_MULTU;
    assign accept  = bus.start && !bus.flush;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op        (step_op),
        .acc_i     (acc_q),
        .mplr_i    (mplr_q),
        .operand_i (opnd_q),
        .acc_o     (step_acc),
        .mplr_o    (step_mplr)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mplr_d    = mplr_q;
        opnd_d    = opnd_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        divzero_d = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    cnt_d = CNT_W'(WIDTH);
                    acc_d = '0;
                    if (bus.op == OP_MULTU) begin
                        state_d = MUL;
                        busy_d  = 1'b1;
                        mplr_d  = bus.srcb;
                        opnd_d  = bus.srca;
                    end else if (bus.srcb == '0) begin
                        // divide by zero resolves immediately without iterating
                        state_d   = DONE;
                        done_d    = 1'b1;
                        divzero_d = 1'b1;
                        hi_d      = bus.srca;
                        lo_d      = '1;
                        mplr_d    = bus.srca;
                        opnd_d    = bus.srcb;
                    end else begin
                        state_d = DIV;
                        busy_d  = 1'b1;
                        mplr_d  = bus.srca;
                        opnd_d  = bus.srcb;
                    end
                end
            end
            MUL, DIV: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d  = step_acc;
                    mplr_d = step_mplr;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hi_d    = step_acc[WIDTH-1:0];
                        lo_d    = step_mplr;
                    end else begin
                        busy_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mplr_q    <= '0;
            opnd_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mplr_q    <= mplr_d;
            opnd_q    <= opnd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.divzero = divzero_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model checked every cycle plus directed timing cases.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic   clk = 1'b0;
    logic   rst_n;
    state_t state_dbg;

    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(W)) mif();

    muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (mif),
        .state_dbg (state_dbg)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [2*W-1:0] exp_q[$];

    logic         m_busy, m_done, m_dz;
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
    int           m_left;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: product/quotient/remainder from plain arithmetic, result after W busy cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_busy) begin
                if (mif.flush) begin
                    m_busy <= 1'b0;
                end else if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    exp_q.push_back({p_hi, p_lo});
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (mif.start && !mif.flush) begin
                if (mif.op == OP_MULTU) begin
                    {p_hi, p_lo} <= 64'(mif.srca) * 64'(mif.srcb);
                    m_busy <= 1'b1;
                    m_left <= W;
                end else if (mif.srcb == '0) begin
                    m_done <= 1'b1;
                    m_dz   <= 1'b1;
                    m_hi   <= mif.srca;
                    m_lo   <= '1;
                    exp_q.push_back({mif.srca, 32'hFFFF_FFFF});
                end else begin
                    p_hi   <= mif.srca % mif.srcb;
                    p_lo   <= mif.srca / mif.srcb;
                    m_busy <= 1'b1;
                    m_left <= W;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", mif.busy, m_busy);
            check("done", mif.done, m_done);
            check("divzero", mif.divzero, m_dz);
            check("hi", mif.hi, m_hi);
            check("lo", mif.lo, m_lo);
            if (mif.done) begin
                if (exp_q.size() == 0) check("sb_unexpected_done", exp_q.size(), 1);
                else check("sb_result", {mif.hi, mif.lo}, exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int dc, output int bc);
        @(negedge clk);
        mif.start = 1'b1;
        mif.op    = o;
        mif.srca  = a;
        mif.srcb  = b;
        @(negedge clk);
        mif.start = 1'b0;
        dc = 1;
        bc = 0;
        while (!mif.done && dc < 100) begin
            if (mif.busy) bc++;
            @(negedge clk);
            dc++;
        end
        if (!mif.done) check("done_timeout", mif.done, 1);
    endtask

    task automatic wait_done(inout int cyc);
        while (!mif.done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!mif.done) check("done_timeout", mif.done, 1);
    endtask

    int dc, bc, nd;
    logic [W-1:0] va [6] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'hDEAD_BEEF, 32'd1000};
    logic [W-1:0] vb [6] = '{32'h9ABC_DEF0, 32'h1, 32'hFFFF_FFFF, 32'h7777, 32'h10, 32'd999};
    logic         vo [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n     = 1'b0;
        mif.start = 1'b0;
        mif.op    = 1'b0;
        mif.srca  = '0;
        mif.srcb  = '0;
        mif.flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", mif.busy, 0);
        check("rst_done", mif.done, 0);
        check("rst_divzero", mif.divzero, 0);
        check("rst_hi", mif.hi, 0);
        check("rst_lo", mif.lo, 0);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // 1: full-scale multiply
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, bc);
        check("t1_done_cycle", dc, 33);
        check("t1_busy_cycles", bc, 32);
        check("t1_hi", mif.hi, 32'hFFFF_FFFE);
        check("t1_lo", mif.lo, 32'h0000_0001);

        // 2: divides
        run_op(OP_DIVU, 32'd100, 32'd7, dc, bc);
        check("t2_done_cycle", dc, 33);
        check("t2_lo", mif.lo, 14);
        check("t2_hi", mif.hi, 2);
        check("t2_divzero", mif.divzero, 0);
        run_op(OP_DIVU, 32'd5, 32'd9, dc, bc);
        check("t2b_lo", mif.lo, 0);
        check("t2b_hi", mif.hi, 5);

        // 3: divide by zero
        run_op(OP_DIVU, 32'h1234, 32'h0, dc, bc);
        check("t3_done_cycle", dc, 1);
        check("t3_busy_cycles", bc, 0);
        check("t3_divzero", mif.divzero, 1);
        check("t3_hi", mif.hi, 32'h1234);
        check("t3_lo", mif.lo, 32'hFFFF_FFFF);

        // 4: start ignored while busy, then flush mid-operation
        @(negedge clk);
        mif.start = 1'b1; mif.op = OP_MULTU; mif.srca = 32'd3; mif.srcb = 32'd4;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (4) @(negedge clk);
        mif.start = 1'b1; mif.op = OP_DIVU; mif.srca = 32'd100; mif.srcb = 32'd7;
        @(negedge clk);
        mif.start = 1'b0;
        dc = 6;
        wait_done(dc);
        check("t4_done_cycle", dc, 33);
        check("t4_hi", mif.hi, 0);
        check("t4_lo", mif.lo, 12);
        @(negedge clk);
        mif.start = 1'b1; mif.op = OP_MULTU; mif.srca = 32'd5; mif.srcb = 32'd5;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (9) @(negedge clk);
        mif.flush = 1'b1;
        @(negedge clk);
        mif.flush = 1'b0;
        check("t4_flush_busy", mif.busy, 0);
        check("t4_flush_state", 64'(state_dbg), 64'(IDLE));
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (mif.done) nd++;
        end
        check("t4_no_done", nd, 0);
        check("t4_keep_hi", mif.hi, 0);
        check("t4_keep_lo", mif.lo, 12);

        // 5: asynchronous reset mid-operation
        @(negedge clk);
        mif.start = 1'b1; mif.op = OP_MULTU; mif.srca = 32'd9; mif.srcb = 32'd9;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", mif.busy, 0);
        check("t5_rst_hi", mif.hi, 0);
        check("t5_rst_lo", mif.lo, 0);
        check("t5_rst_state", 64'(state_dbg), 64'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_MULTU, 32'd6, 32'd7, dc, bc);
        check("t5_done_cycle", dc, 33);
        check("t5_lo", mif.lo, 42);
        check("t5_hi", mif.hi, 0);

        // 6: back-to-back start during the done cycle
        run_op(OP_MULTU, 32'd2, 32'd3, dc, bc);
        check("t6_first_lo", mif.lo, 6);
        mif.start = 1'b1; mif.op = OP_MULTU; mif.srca = 32'd10; mif.srcb = 32'd11;
        @(negedge clk);
        mif.start = 1'b0;
        check("t6_busy_next", mif.busy, 1);
        check("t6_state_next", 64'(state_dbg), 64'(MUL));
        dc = 1;
        wait_done(dc);
        check("t6_gap", dc, W + 1);
        check("t6_lo", mif.lo, 110);

        // model-checked mix of operands
        for (int i = 0; i < 6; i++) begin
            run_op(vo[i], va[i], vb[i], dc, bc);
            check("mix_done_cycle", dc, 33);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
